// File: rtl/search_engine_param.sv
// search_engine_param
// Bit-vector packet classifier. The key is cut into NUM_STAGES chunks of
// STRIDE bits. Each chunk addresses its own BV RAM. The BVs of the enabled
// stages are AND-ed together, and the lowest set bit of the result is the
// winning rule. All BV RAMs and the stage-enable mask are reached through an
// ale-style local bus. BVs wider than 32 bits are moved through a shadow
// register, one 32-bit word at a time.

module search_engine_param #(
   parameter  int NUM_STAGES = 8,
   parameter  int STRIDE     = 9,
   parameter  int BV_W       = 36,
   localparam int KEY_W      = NUM_STAGES * STRIDE,
   localparam int IDX_W      = (BV_W > 1) ? $clog2(BV_W) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_in_valid,
   input  logic [KEY_W-1:0] key_in,
   output logic             bv_out_valid,
   output logic [BV_W-1:0]  bv_out,
   output logic             match_valid,
   output logic             match_hit,
   output logic [IDX_W-1:0] match_idx,
   input  logic             localbus_cs_n,
   input  logic             localbus_rd_wr,
   input  logic [31:0]      localbus_data,
   input  logic             localbus_ale,
   output logic             localbus_ack_n,
   output logic [31:0]      localbus_data_out
);

   localparam int DEPTH  = 1 << STRIDE;
   localparam int NWORDS = (BV_W + 31) / 32;
   localparam int SH_W   = NWORDS * 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RD_WAIT,
      S_BACK
   } cfg_state_e;

   // ---------------------------------------------------------------------
   // Configuration-port state
   // ---------------------------------------------------------------------
   cfg_state_e            state_q, state_d;
   logic [31:0]           addr_q, addr_d;
   logic [SH_W-1:0]       shadow_q, shadow_d;
   logic                  ack_n_q, ack_n_d;
   logic [31:0]           data_out_q, data_out_d;
   logic [NUM_STAGES-1:0] stage_mask_q, stage_mask_d;

   // Address fields. They are decoded from the latched address.
   logic                  addr_is_reg;
   logic [3:0]            addr_word;
   logic [STRIDE-1:0]     addr_entry;
   logic [3:0]            addr_stage;
   logic                  ram_in_range;
   logic                  reg_mask_sel;

   // RAM write port. The config FSM is its only user.
   logic                  ram_we;
   logic [BV_W-1:0]       ram_wr_data;

   // Registered RAM read data, one entry per stage.
   logic [BV_W-1:0]       stage_bv [NUM_STAGES];
   logic [BV_W-1:0]       cfg_rd   [NUM_STAGES];

   // Word 0 of a config read, zero-padded up to the full shadow width.
   logic [SH_W-1:0]       cfg_rd_pad;

   // ---------------------------------------------------------------------
   // Lookup pipeline state
   // ---------------------------------------------------------------------
   logic                  lkp_v1_q, lkp_v1_d;
   logic                  bv_out_valid_q, bv_out_valid_d;
   logic [BV_W-1:0]       bv_out_q, bv_out_d;
   logic                  match_valid_q, match_valid_d;
   logic                  match_hit_q, match_hit_d;
   logic [IDX_W-1:0]      match_idx_q, match_idx_d;

   assign addr_is_reg  = addr_q[31];
   assign addr_word    = addr_q[3:0];
   assign addr_entry   = addr_q[STRIDE+3:4];
   assign addr_stage   = addr_q[STRIDE+7:STRIDE+4];
   assign ram_in_range = !addr_is_reg
                         && (int'(addr_stage) < NUM_STAGES)
                         && (int'(addr_word) < NWORDS);
   assign reg_mask_sel = addr_is_reg && (addr_q[30:0] == 31'd0);

   // ---------------------------------------------------------------------
   // Per-stage BV RAM: one write port (config), two registered read ports
   // (lookup chunk and config entry).
   // ---------------------------------------------------------------------
   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      logic [BV_W-1:0] ram [DEPTH];
      logic [BV_W-1:0] rd_lkp_q;
      logic [BV_W-1:0] rd_cfg_q;

      // RAM write and both registered reads. A lookup that collides with a commit reads the old entry.
      // NOTE: all three use <=, so each read samples the array before this
      // edge's write lands. That gives read-old-data on a collision without
      // any bypass logic. A blocking write here would instead leak the new data
      // into the same-cycle lookup.
      // NOTE: the RAM array and its read registers get no reset. Clearing a
      // memory cannot be done in one cycle, and it would stop the tool from
      // mapping the array onto block RAM. Software programs every entry it
      // relies on.
      always_ff @(posedge clk) begin
         if (ram_we && (addr_stage == 4'(s))) begin
            ram[addr_entry] <= ram_wr_data;
         end
         rd_lkp_q <= ram[key_in[s*STRIDE +: STRIDE]];
         rd_cfg_q <= ram[addr_entry];
      end

      assign stage_bv[s] = rd_lkp_q;
      assign cfg_rd[s]   = rd_cfg_q;
   end

   // ---------------------------------------------------------------------
   // Config FSM: next state, shadow and mask updates, and the RAM commit.
   // ---------------------------------------------------------------------
   // Decode local-bus transfers. The last word of a RAM write commits the shadow to RAM.
   always_comb begin
      // NOTE: every signal driven in this block gets a default value first.
      // Any path that leaves a signal unassigned would otherwise infer a latch.
      state_d      = state_q;
      addr_d       = addr_q;
      shadow_d     = shadow_q;
      ack_n_d      = ack_n_q;
      data_out_d   = data_out_q;
      stage_mask_d = stage_mask_q;
      ram_we       = 1'b0;
      ram_wr_data  = '0;
      cfg_rd_pad   = '0;

      unique case (state_q)
         S_IDLE: begin
            if (localbus_ale) begin
               addr_d  = localbus_data;
               state_d = localbus_rd_wr ? S_RD : S_WR;
            end
         end

         S_WR: begin
            if (!localbus_cs_n) begin
               if (reg_mask_sel) begin
                  stage_mask_d = localbus_data[NUM_STAGES-1:0];
               end else if (ram_in_range) begin
                  for (int w = 0; w < NWORDS; w++) begin
                     if (addr_word == 4'(w)) begin
                        shadow_d[w*32 +: 32] = localbus_data;
                     end
                  end
                  // The last word carries the upper bits and completes the entry.
                  // A reset in the same cycle cancels the commit.
                  if (int'(addr_word) == NWORDS - 1) begin
                     ram_we      = !reset;
                     ram_wr_data = shadow_d[BV_W-1:0];
                  end
               end
               ack_n_d = 1'b0;
               state_d = S_BACK;
            end
         end

         S_RD: begin
            if (!localbus_cs_n) begin
               if (ram_in_range && (addr_word == 4'd0)) begin
                  // Word 0 fetches the whole entry. The RAM answers next cycle.
                  state_d = S_RD_WAIT;
               end else begin
                  data_out_d = '0;
                  if (reg_mask_sel) begin
                     data_out_d[NUM_STAGES-1:0] = stage_mask_q;
                  end else if (ram_in_range) begin
                     for (int w = 0; w < NWORDS; w++) begin
                        if (addr_word == 4'(w)) begin
                           data_out_d = shadow_q[w*32 +: 32];
                        end
                     end
                  end
                  ack_n_d = 1'b0;
                  state_d = S_BACK;
               end
            end
         end

         S_RD_WAIT: begin
            for (int s = 0; s < NUM_STAGES; s++) begin
               if (int'(addr_stage) == s) begin
                  cfg_rd_pad[BV_W-1:0] = cfg_rd[s];
               end
            end
            shadow_d   = cfg_rd_pad;
            data_out_d = cfg_rd_pad[31:0];
            ack_n_d    = 1'b0;
            state_d    = S_BACK;
         end

         S_BACK: begin
            if (localbus_cs_n) begin
               ack_n_d = 1'b1;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Config registers. A synchronous reset aborts any transfer that is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         shadow_q     <= '0;
         ack_n_q      <= 1'b1;
         data_out_q   <= '0;
         stage_mask_q <= '1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         shadow_q     <= shadow_d;
         ack_n_q      <= ack_n_d;
         data_out_q   <= data_out_d;
         stage_mask_q <= stage_mask_d;
      end
   end

   // ---------------------------------------------------------------------
   // Lookup pipeline: C1 RAM read, C2 masked AND, C3 priority encode.
   // ---------------------------------------------------------------------
   // Combine the stage BVs and find the lowest set bit of the registered result.
   always_comb begin
      lkp_v1_d       = key_in_valid;
      bv_out_valid_d = lkp_v1_q;
      bv_out_d       = bv_out_q;
      match_valid_d  = bv_out_valid_q;
      match_hit_d    = match_hit_q;
      match_idx_d    = match_idx_q;

      if (lkp_v1_q) begin
         // A disabled stage contributes all ones, so it has no effect on the AND.
         bv_out_d = '1;
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (stage_mask_q[s]) begin
               bv_out_d = bv_out_d & stage_bv[s];
            end
         end
      end

      if (bv_out_valid_q) begin
         match_hit_d = |bv_out_q;
         match_idx_d = '0;
         // Scan from the top down, so the lowest set bit is written last and wins.
         for (int i = BV_W - 1; i >= 0; i--) begin
            if (bv_out_q[i]) begin
               match_idx_d = IDX_W'(i);
            end
         end
      end
   end

   // Pipeline registers. A reset drops every key that is still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         lkp_v1_q       <= 1'b0;
         bv_out_valid_q <= 1'b0;
         bv_out_q       <= '0;
         match_valid_q  <= 1'b0;
         match_hit_q    <= 1'b0;
         match_idx_q    <= '0;
      end else begin
         lkp_v1_q       <= lkp_v1_d;
         bv_out_valid_q <= bv_out_valid_d;
         bv_out_q       <= bv_out_d;
         match_valid_q  <= match_valid_d;
         match_hit_q    <= match_hit_d;
         match_idx_q    <= match_idx_d;
      end
   end

   assign bv_out_valid      = bv_out_valid_q;
   assign bv_out            = bv_out_q;
   assign match_valid       = match_valid_q;
   assign match_hit         = match_hit_q;
   assign match_idx         = match_idx_q;
   assign localbus_ack_n    = ack_n_q;
   assign localbus_data_out = data_out_q;

endmodule

// File: tb/tb_search_engine_param.sv
// tb_search_engine_param
// Directed bench for search_engine_param with 8 stages, 9-bit stride and
// 36-bit BVs. Inputs change on the falling edge and outputs are sampled on the
// falling edge, well away from the active rising edge.

module tb_search_engine_param;

   localparam int NS = 8;
   localparam int ST = 9;
   localparam int BW = 36;

   logic          clk = 1'b0;
   logic          reset;
   logic          key_in_valid;
   logic [NS*ST-1:0] key_in;
   logic          bv_out_valid;
   logic [BW-1:0] bv_out;
   logic          match_valid;
   logic          match_hit;
   logic [5:0]    match_idx;
   logic          lb_cs_n;
   logic          lb_rd_wr;
   logic [31:0]   lb_data;
   logic          lb_ale;
   logic          lb_ack_n;
   logic [31:0]   lb_data_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   search_engine_param #(
      .NUM_STAGES(NS),
      .STRIDE    (ST),
      .BV_W      (BW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .key_in_valid     (key_in_valid),
      .key_in           (key_in),
      .bv_out_valid     (bv_out_valid),
      .bv_out           (bv_out),
      .match_valid      (match_valid),
      .match_hit        (match_hit),
      .match_idx        (match_idx),
      .localbus_cs_n    (lb_cs_n),
      .localbus_rd_wr   (lb_rd_wr),
      .localbus_data    (lb_data),
      .localbus_ale     (lb_ale),
      .localbus_ack_n   (lb_ack_n),
      .localbus_data_out(lb_data_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ram_addr(input int stage, input int entry, input int w);
      return 32'((stage << (ST + 4)) | (entry << 4) | w);
   endfunction

   // Wait for ack_n to go low, then release cs_n and wait for ack_n to go high again. Both waits are bounded.
   task automatic finish_xfer(output logic ok, output logic [31:0] rd);
      logic got = 1'b0;
      logic rel = 1'b0;
      rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (lb_ack_n == 1'b0) begin
            got = 1'b1;
            rd  = lb_data_out;
            break;
         end
      end
      lb_cs_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (lb_ack_n == 1'b1) begin
            rel = 1'b1;
            break;
         end
      end
      ok = got & rel;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
      logic [31:0] unused_rd;
      @(negedge clk);
      lb_ale = 1'b1; lb_rd_wr = 1'b0; lb_data = a;
      @(negedge clk);
      lb_ale = 1'b0; lb_data = d; lb_cs_n = 1'b0;
      finish_xfer(ok, unused_rd);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
      @(negedge clk);
      lb_ale = 1'b1; lb_rd_wr = 1'b1; lb_data = a;
      @(negedge clk);
      lb_ale = 1'b0; lb_cs_n = 1'b0;
      finish_xfer(ok, d);
   endtask

   // Send one key, then sample the outputs at the falling edges that land 1, 2 and 3 cycles after the key cycle.
   task automatic lookup(input logic [NS*ST-1:0] k, output logic early, output logic bvv,
                         output logic [BW-1:0] bv, output logic mv, output logic hit,
                         output logic [5:0] idx);
      @(negedge clk);
      key_in = k; key_in_valid = 1'b1;
      @(negedge clk);
      key_in_valid = 1'b0;
      early = bv_out_valid | match_valid;
      @(negedge clk);
      bvv = bv_out_valid; bv = bv_out;
      early = early | match_valid;
      @(negedge clk);
      mv = match_valid; hit = match_hit; idx = match_idx;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        ok;
      logic [31:0] rd;
      logic        early, bvv, mv, hit;
      logic [BW-1:0] bv;
      logic [5:0]  idx;

      reset = 1'b1; key_in_valid = 1'b0; key_in = '0;
      lb_cs_n = 1'b1; lb_rd_wr = 1'b0; lb_data = '0; lb_ale = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1. Reset values and the stage mask after reset.
      check("rst_bvv", bv_out_valid, 0);
      check("rst_mv", match_valid, 0);
      check("rst_bv", bv_out, 0);
      check("rst_hit", match_hit, 0);
      check("rst_idx", match_idx, 0);
      check("rst_ack", lb_ack_n, 1);
      check("rst_dout", lb_data_out, 0);
      bus_read(32'h8000_0000, rd, ok);
      check("mask_rd_ack", ok, 1);
      check("mask_rd", rd, 32'hFF);
      bus_read(32'h8000_0004, rd, ok);
      check("reg_other_rd", rd, 0);

      // 2. Two-word write to stage 2, entry 0x1A5, then read it back.
      bus_write(ram_addr(2, 'h1A5, 0), 32'h0000_0010, ok);
      check("wr_w0_ack", ok, 1);
      bus_write(ram_addr(2, 'h1A5, 1), 32'h0000_0008, ok);
      check("wr_w1_ack", ok, 1);
      bus_read(ram_addr(2, 'h1A5, 0), rd, ok);
      check("rd_w0_ack", ok, 1);
      check("rd_w0", rd, 32'h10);
      bus_read(ram_addr(2, 'h1A5, 1), rd, ok);
      check("rd_w1_ack", ok, 1);
      check("rd_w1", rd, 32'h8);

      // 3. Entry 0 of every stage is 0xF0, except stage 5 which is 0x30. Key 0 gives 0x30 and index 4.
      for (int s = 0; s < NS; s++) begin
         bus_write(ram_addr(s, 0, 0), (s == 5) ? 32'h30 : 32'hF0, ok);
         bus_write(ram_addr(s, 0, 1), 32'h0, ok);
      end
      lookup('0, early, bvv, bv, mv, hit, idx);
      check("t3_early", early, 0);
      check("t3_bvv", bvv, 1);
      check("t3_bv", bv, 36'h30);
      check("t3_mv", mv, 1);
      check("t3_hit", hit, 1);
      check("t3_idx", idx, 4);

      // 4. Disable stage 5, then clear stage 0 entry 0, then set the mask to zero.
      bus_write(32'h8000_0000, 32'hDF, ok);
      lookup('0, early, bvv, bv, mv, hit, idx);
      check("t4_bv_masked", bv, 36'hF0);
      check("t4_idx_masked", idx, 4);
      bus_write(ram_addr(0, 0, 0), 32'h0, ok);
      bus_write(ram_addr(0, 0, 1), 32'h0, ok);
      lookup('0, early, bvv, bv, mv, hit, idx);
      check("t4_bv_zero", bv, 0);
      check("t4_hit_zero", hit, 0);
      check("t4_idx_zero", idx, 0);
      bus_write(32'h8000_0000, 32'h0, ok);
      lookup('0, early, bvv, bv, mv, hit, idx);
      check("t4_bv_nomask", bv, 36'hF_FFFF_FFFF);
      check("t4_hit_nomask", hit, 1);
      check("t4_idx_nomask", idx, 0);

      // 5. Ten back-to-back keys. Only stage 3 is enabled, and entry 0 changes from 0xF0 to 0x5 during the stream.
      //    The commit lands on the same edge that samples key 1, so keys 0 and 1 see 0xF0 and keys 2..9 see 0x5.
      bus_write(32'h8000_0000, 32'h08, ok);
      bus_write(ram_addr(3, 0, 0), 32'h5, ok);
      for (int cyc = 0; cyc < 13; cyc++) begin
         @(negedge clk);
         if (cyc >= 2 && cyc < 12) begin
            check("t5_bvv", bv_out_valid, 1);
            check("t5_bv", bv_out, (cyc - 2 < 2) ? 36'hF0 : 36'h5);
         end else begin
            check("t5_bvv_idle", bv_out_valid, 0);
         end
         if (cyc >= 3) begin
            check("t5_mv", match_valid, 1);
            check("t5_idx", match_idx, (cyc - 3 < 2) ? 6'd4 : 6'd0);
         end
         if (cyc == 2) check("t5_ack_low", lb_ack_n, 0);
         if (cyc == 3) check("t5_ack_high", lb_ack_n, 1);
         key_in_valid = (cyc < 10);
         key_in       = '0;
         lb_ale       = (cyc == 0);
         if (cyc == 0) begin lb_rd_wr = 1'b0; lb_data = ram_addr(3, 0, 1); end
         if (cyc == 1) begin lb_data = 32'h0; lb_cs_n = 1'b0; end
         if (cyc == 2) lb_cs_n = 1'b1;
      end

      // A reset in the middle of a lookup drops the key.
      @(negedge clk);
      key_in_valid = 1'b1;
      @(negedge clk);
      key_in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_drop_bvv", bv_out_valid, 0);
      @(negedge clk);
      check("t6_drop_mv", match_valid, 0);

      // 6a. Reset while the FSM is in RD_WAIT.
      @(negedge clk);
      lb_ale = 1'b1; lb_rd_wr = 1'b1; lb_data = ram_addr(2, 'h1A5, 0);
      @(negedge clk);
      lb_ale = 1'b0; lb_cs_n = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; lb_cs_n = 1'b1;
      check("t6a_ack", lb_ack_n, 1);
      check("t6a_dout", lb_data_out, 0);
      bus_read(32'h8000_0000, rd, ok);
      check("t6a_idle_ok", ok, 1);
      check("t6a_mask", rd, 32'hFF);

      // 6b. Write w0, then reset during the w1 cycle. No commit may happen.
      bus_write(ram_addr(2, 'h1A5, 0), 32'hDEAD_BEEF, ok);
      @(negedge clk);
      lb_ale = 1'b1; lb_rd_wr = 1'b0; lb_data = ram_addr(2, 'h1A5, 1);
      @(negedge clk);
      lb_ale = 1'b0; lb_data = 32'h7; lb_cs_n = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; lb_cs_n = 1'b1;
      check("t6b_ack", lb_ack_n, 1);
      // A write of w1 alone must commit a cleared shadow word 0.
      bus_write(ram_addr(1, 7, 1), 32'h3, ok);
      check("t6b_w1_ack", ok, 1);
      bus_read(ram_addr(1, 7, 0), rd, ok);
      check("t6b_shadow_w0", rd, 32'h0);
      bus_read(ram_addr(1, 7, 1), rd, ok);
      check("t6b_shadow_w1", rd, 32'h3);
      bus_read(ram_addr(2, 'h1A5, 0), rd, ok);
      check("t6b_keep_w0", rd, 32'h10);
      bus_read(ram_addr(2, 'h1A5, 1), rd, ok);
      check("t6b_keep_w1", rd, 32'h8);

      // Out-of-range accesses: stage 9, and word 2.
      bus_write(ram_addr(9, 0, 0), 32'h1234, ok);
      check("oor_wr_ack", ok, 1);
      bus_read(ram_addr(9, 0, 0), rd, ok);
      check("oor_rd_ack", ok, 1);
      check("oor_rd", rd, 0);
      bus_read(ram_addr(2, 'h1A5, 2), rd, ok);
      check("oor_word_rd", rd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
